// File: rtl/acl_pkg.sv
// Shared encodings and field positions for the accelerometer tilt filter.
// The magnitude helper is used by the hysteresis FSM.
package acl_pkg;

    typedef enum logic [1:0] {
        CENTER = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2
    } tilt_state_e;

    localparam int ACL_X_MSB     = 9;
    localparam int ACL_X_LSB     = 5;
    localparam int ACL_X_W       = 5;
    localparam int INTENSITY_MAX = 15;

    // |m| clipped to 4 bits; only -16 actually clips
    function automatic logic [3:0] sat_mag(input logic signed [ACL_X_W-1:0] m);
        logic signed [ACL_X_W:0] e;
        logic signed [ACL_X_W:0] a;
        e = {m[ACL_X_W-1], m};
        a = e[ACL_X_W] ? -e : e;
        return (a > 6'sd15) ? 4'(INTENSITY_MAX) : a[3:0];
    endfunction

endpackage

// File: rtl/tilt_hysteresis_fsm.sv
// LEFT/RIGHT/CENTER decision with enter/exit hysteresis, evaluated once per
// closed averaging window; force_center_i overrides any update.
module tilt_hysteresis_fsm
    import acl_pkg::*;
#(
    parameter int ENTER_TH = 3,
    parameter int EXIT_TH  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [ACL_X_W-1:0] mean_i,
    input  logic                      update_i,
    input  logic                      force_center_i,
    output tilt_state_e               state_o,
    output logic [3:0]                intensity_o
);

    localparam logic signed [ACL_X_W:0] ENT_P = (ACL_X_W+1)'(ENTER_TH);
    localparam logic signed [ACL_X_W:0] ENT_N = -ENT_P;
    localparam logic signed [ACL_X_W:0] EXT_P = (ACL_X_W+1)'(EXIT_TH);
    localparam logic signed [ACL_X_W:0] EXT_N = -EXT_P;

    tilt_state_e       state_q, state_d;
    logic [3:0]        intensity_q, intensity_d;
    logic signed [ACL_X_W:0] m;

    assign m = {mean_i[ACL_X_W-1], mean_i};

    always_comb begin
        state_d     = state_q;
        intensity_d = intensity_q;
        if (force_center_i) begin
            state_d     = CENTER;
            intensity_d = 4'd0;
        end else if (update_i) begin
            unique case (state_q)
                CENTER: begin
                    if (m <= ENT_N)      state_d = RIGHT;
                    else if (m >= ENT_P) state_d = LEFT;
                end
                RIGHT: begin
                    if (m >= ENT_P)      state_d = LEFT;
                    else if (m > EXT_N)  state_d = CENTER;
                end
                LEFT: begin
                    if (m <= ENT_N)      state_d = RIGHT;
                    else if (m < EXT_P)  state_d = CENTER;
                end
                default:                 state_d = CENTER;
            endcase
            intensity_d = (state_d != CENTER) ? sat_mag(mean_i) : 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CENTER;
            intensity_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            intensity_q <= intensity_d;
        end
    end

    assign state_o     = state_q;
    assign intensity_o = intensity_q;

endmodule

// File: rtl/acl_tilt_filter.sv
// Windowed average of the accelerometer X field feeding a hysteresis FSM,
// with an idle watchdog that forces CENTER when the sample stream stalls.
module acl_tilt_filter
    import acl_pkg::*;
#(
    parameter int AVG_LOG2    = 2,
    parameter int ENTER_TH    = 3,
    parameter int EXIT_TH     = 1,
    parameter int TIMEOUT_CYC = 4000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [14:0] acl_data,
    output logic        tilt_left,
    output logic        tilt_right,
    output logic [3:0]  tilt_intensity,
    output logic        out_valid,
    output logic        timeout
);

    localparam int ACC_W = ACL_X_W + AVG_LOG2;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    if (EXIT_TH > ENTER_TH || ENTER_TH > INTENSITY_MAX || ENTER_TH < 1 ||
        EXIT_TH < 0 || AVG_LOG2 < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $fatal(1, "acl_tilt_filter: illegal parameter combination");
    end

    logic signed [ACC_W-1:0]   acc_q, acc_d, x_ext, sum;
    logic [AVG_LOG2-1:0]       cnt_q, cnt_d;
    logic [TMR_W-1:0]          tmr_q, tmr_d;
    logic                      timeout_q, timeout_d, out_valid_q;
    logic                      close, expire;
    logic signed [ACL_X_W-1:0] mean;
    tilt_state_e               state;
    logic                      unused_acl_bits;

    assign unused_acl_bits = ^{acl_data[14:ACL_X_MSB+1], acl_data[ACL_X_LSB-1:0]};

    assign x_ext  = {{AVG_LOG2{acl_data[ACL_X_MSB]}}, acl_data[ACL_X_MSB:ACL_X_LSB]};
    assign sum    = acc_q + x_ext;
    assign mean   = ACL_X_W'(sum >>> AVG_LOG2);
    assign close  = sample_valid && (cnt_q == '1);
    // A sample arriving on the expiry cycle suppresses the timeout
    assign expire = !sample_valid && !timeout_q && (tmr_q == TMR_LAST);

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        timeout_d = timeout_q;
        if (sample_valid) begin
            acc_d     = close ? '0 : sum;
            cnt_d     = cnt_q + 1'b1;
            tmr_d     = '0;
            timeout_d = 1'b0;
        end else if (expire) begin
            acc_d     = '0;
            cnt_d     = '0;
            timeout_d = 1'b1;
        end else if (tmr_q != TMR_LAST) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            tmr_q       <= '0;
            timeout_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            timeout_q   <= timeout_d;
            out_valid_q <= close | expire;
        end
    end

    tilt_hysteresis_fsm #(
        .ENTER_TH (ENTER_TH),
        .EXIT_TH  (EXIT_TH)
    ) u_fsm (
        .clk            (clk),
        .rst            (rst),
        .mean_i         (mean),
        .update_i       (close),
        .force_center_i (expire),
        .state_o        (state),
        .intensity_o    (tilt_intensity)
    );

    assign tilt_left  = (state == LEFT);
    assign tilt_right = (state == RIGHT);
    assign out_valid  = out_valid_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_acl_tilt_filter.sv
// Directed bench for acl_tilt_filter: averaging, hysteresis, saturation,
// idle timeout and mid-window reset, with hand-computed expectations.
module tb_acl_tilt_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [14:0] acl_data;
    logic        tilt_left, tilt_right, out_valid, timeout;
    logic [3:0]  tilt_intensity;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acl_tilt_filter #(
        .AVG_LOG2    (2),
        .ENTER_TH    (3),
        .EXIT_TH     (1),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_valid   (sample_valid),
        .acl_data       (acl_data),
        .tilt_left      (tilt_left),
        .tilt_right     (tilt_right),
        .tilt_intensity (tilt_intensity),
        .out_valid      (out_valid),
        .timeout        (timeout)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Neighbouring bits carry junk so the X field extraction is exercised
    task automatic send(input int x);
        logic [4:0] xf;
        xf           = 5'(x);
        sample_valid = 1'b1;
        acl_data     = {5'b10110, xf, 5'b01101};
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic window(input int a, input int b, input int c, input int d);
        send(a); send(b); send(c); send(d);
    endtask

    task automatic expect_out(input string tag, input int ov, input int l,
                              input int r, input int inten);
        chk({tag, "_ov"},  int'(out_valid),      ov);
        chk({tag, "_l"},   int'(tilt_left),      l);
        chk({tag, "_r"},   int'(tilt_right),     r);
        chk({tag, "_int"}, int'(tilt_intensity), inten);
    endtask

    initial begin
        int ovcnt;
        rst          = 1'b1;
        sample_valid = 1'b0;
        acl_data     = '0;
        repeat (3) tick();
        expect_out("rst", 0, 0, 0, 0);
        chk("rst_to", int'(timeout), 0);
        rst = 1'b0;

        // 1: steady right tilt
        window(-8, -8, -8, -8);
        expect_out("t1", 1, 0, 1, 8);
        tick();
        expect_out("t1_hold", 0, 0, 1, 8);

        // 2: hysteresis
        window(-2, -2, -2, -2);
        expect_out("t2_keep", 1, 0, 1, 2);
        window(0, 0, 0, 0);
        expect_out("t2_exit", 1, 0, 0, 0);
        window(1, 2, 3, 2);
        expect_out("t2_noent", 1, 0, 0, 0);

        // 3: direct swap
        window(-5, -5, -5, -5);
        expect_out("t3_r", 1, 0, 1, 5);
        window(6, 6, 6, 6);
        expect_out("t3_swap", 1, 1, 0, 6);

        // 4: saturation and floor rounding
        window(-16, -16, -16, -16);
        expect_out("t4_sat", 1, 0, 1, 15);
        window(-1, 0, 0, 0);
        expect_out("t4_floor_r", 1, 0, 1, 1);
        window(0, 0, 0, 0);
        expect_out("t4_ctr", 1, 0, 0, 0);
        window(-1, 0, 0, 0);
        expect_out("t4_floor_c", 1, 0, 0, 0);

        // 5: idle timeout from LEFT
        window(6, 6, 6, 6);
        expect_out("t5_l", 1, 1, 0, 6);
        ovcnt = 0;
        for (int i = 0; i < 99; i++) begin
            tick();
            ovcnt += int'(out_valid);
        end
        chk("t5_pre_ov", ovcnt, 0);
        chk("t5_pre_to", int'(timeout), 0);
        chk("t5_pre_l", int'(tilt_left), 1);
        tick();
        expect_out("t5_exp", 1, 0, 0, 0);
        chk("t5_exp_to", int'(timeout), 1);
        tick();
        chk("t5_after_ov", int'(out_valid), 0);
        chk("t5_after_to", int'(timeout), 1);
        send(8);
        chk("t5_clr_to", int'(timeout), 0);
        chk("t5_clr_ov", int'(out_valid), 0);
        repeat (99) tick();
        send(8);
        chk("t5_race_to", int'(timeout), 0);
        chk("t5_race_ov", int'(out_valid), 0);
        tick();
        chk("t5_race_to2", int'(timeout), 0);
        send(8);
        send(8);
        expect_out("t5_win", 1, 1, 0, 8);

        // 6: reset mid-window discards partial sums
        send(15); send(15); send(15);
        chk("t6_pre_ov", int'(out_valid), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("t6_rst", 0, 0, 0, 0);
        window(0, 0, 0, 0);
        expect_out("t6_win", 1, 0, 0, 0);
        window(4, 4, 4, 4);
        expect_out("t6_align", 1, 1, 0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
